// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-RAM arbiter: port ids, word size, byte-enable expansion.
package dmem_arb_pkg;

  typedef logic [0:0] port_id_t;

  localparam port_id_t PORT_CORE = 1'b0;
  localparam port_id_t PORT_DBG  = 1'b1;

  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] be2mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      mask[8*k +: 8] = {8{be[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Bundle of both requester ports plus the single-port RAM side of the data-RAM arbiter.
interface dmem_arb_if #(
  parameter int ADDR_W = 13
);
  logic              req0, req1;
  logic              gnt0, gnt1;
  logic [31:0]       addr0, addr1;
  logic              we0, we1;
  logic [3:0]        be0, be1;
  logic [31:0]       wdata0, wdata1;
  logic              rvalid0, rvalid1;
  logic [31:0]       rdata0, rdata1;
  logic              err0, err1;
  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wmask;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  req0, req1, addr0, addr1, we0, we1, be0, be1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           ram_cs, ram_we, ram_addr, ram_wmask, ram_wdata
  );

  modport master (
    output req0, req1, addr0, addr1, we0, we1, be0, be1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           ram_cs, ram_we, ram_addr, ram_wmask, ram_wdata
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational two-way grant pick; DMEM_ARB_RR_EN selects round-robin (last_winner flop),
// otherwise port 0 has fixed priority. Grants are suppressed while reset is asserted.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req0,
  input  logic     req1,
  output logic     gnt0,
  output logic     gnt1,
  output logic     vld,
  output port_id_t win
);

  port_id_t conflict_win;

`ifdef DMEM_ARB_RR_EN
  port_id_t last_winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= PORT_DBG;
    end else if (vld) begin
      last_winner <= win;
    end
  end

  assign conflict_win = ~last_winner;
`else
  logic unused_clk;
  assign unused_clk   = clk;
  assign conflict_win = PORT_CORE;
`endif

  always_comb begin
    win = PORT_CORE;
    if (req0 && req1) begin
      win = conflict_win;
    end else if (req1) begin
      win = PORT_DBG;
    end
  end

  // rst_n gating keeps an in-flight request from being granted during reset
  assign vld  = rst_n && (req0 || req1);
  assign gnt0 = vld && (win == PORT_CORE);
  assign gnt1 = vld && (win == PORT_DBG);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between core (port 0) and debug/loader (port 1); 0-cycle grant,
// response 1 cycle later; loser simply sees gnt low and holds. DMEM_ARB_RR_EN enables round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
  parameter int          ADDR_W    = 13
) (
  input  logic      HCLK,
  input  logic      HRESETn,
  dmem_arb_if.slave bus
);

  logic        gnt0, gnt1, vld;
  port_id_t    win;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be;
  logic        sel_we;
  logic        in_win;

  logic        rsp_vld, rsp_err, rsp_we;
  port_id_t    rsp_id;
  logic [31:0] rsp_rdata;

  dmem_arb_pick u_pick (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .req0  (bus.req0),
    .req1  (bus.req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .vld   (vld),
    .win   (win)
  );

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;

  assign sel_addr  = (win == PORT_DBG) ? bus.addr1  : bus.addr0;
  assign sel_wdata = (win == PORT_DBG) ? bus.wdata1 : bus.wdata0;
  assign sel_be    = (win == PORT_DBG) ? bus.be1    : bus.be0;
  assign sel_we    = (win == PORT_DBG) ? bus.we1    : bus.we0;

  assign in_win = (sel_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

  // Byte offset is irrelevant to a word-wide RAM
  logic unused_addr_bits;
  assign unused_addr_bits = ^sel_addr[1:0];

  always_comb begin
    bus.ram_cs    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wmask = '0;
    bus.ram_wdata = '0;
    if (vld && in_win) begin
      bus.ram_cs    = 1'b1;
      bus.ram_we    = sel_we;
      bus.ram_addr  = sel_addr[ADDR_W+1:2];
      bus.ram_wmask = be2mask(sel_be);
      bus.ram_wdata = sel_wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_vld <= 1'b0;
      rsp_id  <= PORT_CORE;
      rsp_err <= 1'b0;
      rsp_we  <= 1'b0;
    end else begin
      rsp_vld <= vld;
      rsp_id  <= win;
      rsp_err <= vld && !in_win;
      rsp_we  <= vld && sel_we;
    end
  end

  assign rsp_rdata = (rsp_vld && !rsp_we && !rsp_err) ? bus.ram_rdata : '0;

  assign bus.rvalid0 = rsp_vld && (rsp_id == PORT_CORE);
  assign bus.rvalid1 = rsp_vld && (rsp_id == PORT_DBG);
  assign bus.err0    = rsp_vld && rsp_err && (rsp_id == PORT_CORE);
  assign bus.err1    = rsp_vld && rsp_err && (rsp_id == PORT_DBG);
  assign bus.rdata0  = (rsp_id == PORT_CORE) ? rsp_rdata : '0;
  assign bus.rdata1  = (rsp_id == PORT_DBG)  ? rsp_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural registered single-port RAM.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  dmem_arb_if #(.ADDR_W(13)) bus ();

  dmem_arbiter #(.BASE_ADDR(32'h0010_0000), .ADDR_W(13)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered RAM: write lands at the grant edge, read data appears after it, masked lanes zero
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we)
        mem[bus.ram_addr] <= (mem[bus.ram_addr] & ~bus.ram_wmask) | (bus.ram_wdata & bus.ram_wmask);
      else
        bus.ram_rdata <= mem[bus.ram_addr] & bus.ram_wmask;
    end
  end

  task automatic idle();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.be0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.be1 = '0; bus.wdata1 = '0;
  endtask

  task automatic drv(input bit p, input logic w, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] d);
    if (!p) begin
      bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.be0 = be; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.be1 = be; bus.wdata1 = d;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    drv(1'b0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
    drv(1'b1, 1'b1, 32'h0010_0020, 4'hF, 32'h1);
    @(negedge clk); #1;
    checks++; if (bus.gnt0 !== 1'b0) $display("FAIL rst_gnt0 got %b exp 0", bus.gnt0); else passed++;
    checks++; if (bus.gnt1 !== 1'b0) $display("FAIL rst_gnt1 got %b exp 0", bus.gnt1); else passed++;
    checks++; if (bus.ram_cs !== 1'b0) $display("FAIL rst_ram_cs got %b exp 0", bus.ram_cs); else passed++;
    checks++; if (bus.ram_we !== 1'b0) $display("FAIL rst_ram_we got %b exp 0", bus.ram_we); else passed++;
    checks++; if ({bus.rvalid0, bus.rvalid1, bus.err0, bus.err1} !== 4'b0)
      $display("FAIL rst_rsp got %b exp 0000", {bus.rvalid0, bus.rvalid1, bus.err0, bus.err1}); else passed++;
    checks++; if ({bus.rdata0, bus.rdata1} !== 64'h0)
      $display("FAIL rst_rdata got %h exp 0", {bus.rdata0, bus.rdata1}); else passed++;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    @(negedge clk); idle(); drv(1'b0, 1'b1, 32'h0010_0010, 4'hF, 32'hDEAD_BEEF);
    #1;
    checks++; if (bus.gnt0 !== 1'b1) $display("FAIL wr_gnt0 got %b exp 1", bus.gnt0); else passed++;
    checks++; if ({bus.ram_cs, bus.ram_we} !== 2'b11) $display("FAIL wr_cs_we got %b exp 11", {bus.ram_cs, bus.ram_we}); else passed++;
    checks++; if (bus.ram_addr !== 13'd4) $display("FAIL wr_addr got %0d exp 4", bus.ram_addr); else passed++;
    checks++; if (bus.ram_wmask !== 32'hFFFF_FFFF) $display("FAIL wr_mask got %h exp ffffffff", bus.ram_wmask); else passed++;
    @(posedge clk); #1;
    checks++; if ({bus.rvalid0, bus.err0} !== 2'b10) $display("FAIL wr_rsp got %b exp 10", {bus.rvalid0, bus.err0}); else passed++;
    checks++; if (bus.rdata0 !== 32'h0) $display("FAIL wr_rdata got %h exp 0", bus.rdata0); else passed++;

    @(negedge clk); idle(); drv(1'b0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
    #1;
    checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) $display("FAIL rd_gnt got %b exp 10", {bus.gnt0, bus.gnt1}); else passed++;
    checks++; if ({bus.ram_cs, bus.ram_we} !== 2'b10) $display("FAIL rd_cs_we got %b exp 10", {bus.ram_cs, bus.ram_we}); else passed++;
    @(posedge clk); #1;
    checks++; if ({bus.rvalid0, bus.rvalid1, bus.err0} !== 3'b100) $display("FAIL rd_rsp got %b exp 100", {bus.rvalid0, bus.rvalid1, bus.err0}); else passed++;
    checks++; if (bus.rdata0 !== 32'hDEAD_BEEF) $display("FAIL rd_rdata got %h exp deadbeef", bus.rdata0); else passed++;
    @(negedge clk); idle();
  endtask

  task automatic test_byte_write();
    @(negedge clk); idle(); drv(1'b1, 1'b1, 32'h0010_0008, 4'hF, 32'h1122_3344);
    #1;
    checks++; if ({bus.gnt0, bus.gnt1} !== 2'b01) $display("FAIL bw_init_gnt got %b exp 01", {bus.gnt0, bus.gnt1}); else passed++;
    @(posedge clk); #1;
    checks++; if ({bus.rvalid1, bus.rvalid0} !== 2'b10) $display("FAIL bw_init_rsp got %b exp 10", {bus.rvalid1, bus.rvalid0}); else passed++;
    checks++; if (bus.rdata1 !== 32'h0) $display("FAIL bw_init_rdata got %h exp 0", bus.rdata1); else passed++;

    @(negedge clk); idle(); drv(1'b1, 1'b1, 32'h0010_0008, 4'b0100, 32'h00AB_0000);
    #1;
    checks++; if (bus.ram_wmask !== 32'h00FF_0000) $display("FAIL bw_mask got %h exp 00ff0000", bus.ram_wmask); else passed++;
    checks++; if (bus.ram_addr !== 13'd2) $display("FAIL bw_addr got %0d exp 2", bus.ram_addr); else passed++;
    checks++; if (bus.ram_wdata !== 32'h00AB_0000) $display("FAIL bw_wdata got %h exp 00ab0000", bus.ram_wdata); else passed++;

    @(negedge clk); idle(); drv(1'b1, 1'b0, 32'h0010_0008, 4'hF, 32'h0);
    @(posedge clk); #1;
    checks++; if (bus.rdata1 !== 32'h11AB_3344) $display("FAIL bw_read got %h exp 11ab3344", bus.rdata1); else passed++;
    checks++; if ({bus.rvalid1, bus.err1, bus.rvalid0} !== 3'b100) $display("FAIL bw_read_rsp got %b exp 100", {bus.rvalid1, bus.err1, bus.rvalid0}); else passed++;

    @(negedge clk); idle(); drv(1'b0, 1'b0, 32'h0010_0010, 4'h0, 32'h0);
    #1;
    checks++; if ({bus.gnt0, bus.ram_cs, bus.ram_wmask} !== {2'b11, 32'h0}) $display("FAIL be0_issue got %b/%h exp 11/0", {bus.gnt0, bus.ram_cs}, bus.ram_wmask); else passed++;
    @(posedge clk); #1;
    checks++; if ({bus.rvalid0, bus.rdata0} !== {1'b1, 32'h0}) $display("FAIL be0_rsp got %b/%h exp 1/0", bus.rvalid0, bus.rdata0); else passed++;
    // Leave port 1 as the most recent winner before the conflict test
    @(negedge clk); idle(); drv(1'b1, 1'b0, 32'h0010_0008, 4'hF, 32'h0);
    @(negedge clk); idle();
  endtask

  task automatic test_conflict();
    logic [3:0] exp_g1;
`ifdef DMEM_ARB_RR_EN
    exp_g1 = 4'b1010;
`else
    exp_g1 = 4'b0000;
`endif
    @(negedge clk); idle();
    drv(1'b0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
    drv(1'b1, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if ({bus.gnt0, bus.gnt1} !== {~exp_g1[c], exp_g1[c]})
        $display("FAIL conflict_c%0d got %b exp %b", c, {bus.gnt0, bus.gnt1}, {~exp_g1[c], exp_g1[c]}); else passed++;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_out_of_window();
    @(negedge clk); idle(); drv(1'b0, 1'b0, 32'h0000_1000, 4'hF, 32'h0);
    #1;
    checks++; if ({bus.gnt0, bus.ram_cs} !== 2'b10) $display("FAIL oow_issue got %b exp 10", {bus.gnt0, bus.ram_cs}); else passed++;
    @(posedge clk); #1;
    checks++; if ({bus.rvalid0, bus.err0, bus.err1} !== 3'b110) $display("FAIL oow_rsp got %b exp 110", {bus.rvalid0, bus.err0, bus.err1}); else passed++;
    checks++; if (bus.rdata0 !== 32'h0) $display("FAIL oow_rdata got %h exp 0", bus.rdata0); else passed++;
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid();
    // A response already registered disappears as soon as reset asserts
    @(negedge clk); idle(); drv(1'b0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
    @(posedge clk); #1;
    checks++; if (bus.rvalid0 !== 1'b1) $display("FAIL rm_pending got %b exp 1", bus.rvalid0); else passed++;
    rst_n = 1'b0; idle(); #1;
    checks++; if ({bus.rvalid0, bus.rdata0} !== 33'h0) $display("FAIL rm_drop got %b/%h exp 0/0", bus.rvalid0, bus.rdata0); else passed++;
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); drv(1'b0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
    #1;
    checks++; if (bus.gnt0 !== 1'b1) $display("FAIL rm_gnt got %b exp 1", bus.gnt0); else passed++;
    #1 rst_n = 1'b0; #1;
    checks++; if ({bus.gnt0, bus.ram_cs} !== 2'b00) $display("FAIL rm_gnt_forced got %b exp 00", {bus.gnt0, bus.ram_cs}); else passed++;
    idle(); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.rvalid0 !== 1'b0) $display("FAIL rm_no_rsp got %b exp 0", bus.rvalid0); else passed++;

    @(negedge clk);
    drv(1'b0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
    drv(1'b1, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
    #1;
    checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) $display("FAIL rm_first_conflict got %b exp 10", {bus.gnt0, bus.gnt1}); else passed++;
    @(negedge clk); idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle();
      if (i % 2 == 0) drv(1'b0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
      else            drv(1'b1, 1'b1, 32'h0010_0028, 4'hF, 32'hA0 + i);
      #1;
      checks++; if ({bus.gnt0, bus.gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL b2b_gnt_%0d got %b", i, {bus.gnt0, bus.gnt1}); else passed++;
      @(posedge clk); #1;
      checks++; if ({bus.rvalid0, bus.rvalid1} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL b2b_rvalid_%0d got %b", i, {bus.rvalid0, bus.rvalid1}); else passed++;
      checks++; if ({bus.rdata0, bus.rdata1} !== ((i % 2 == 0) ? {32'hDEAD_BEEF, 32'h0} : 64'h0))
        $display("FAIL b2b_rdata_%0d got %h/%h", i, bus.rdata0, bus.rdata1); else passed++;
    end
    @(negedge clk); idle();
    @(posedge clk); #1;
    checks++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) $display("FAIL b2b_tail got %b exp 00", {bus.rvalid0, bus.rvalid1}); else passed++;
    checks++; if (mem[10] !== 32'h0000_00A7) $display("FAIL b2b_lastwr got %h exp 000000a7", mem[10]); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    idle();
    test_reset();
    test_read();
    test_byte_write();
    test_conflict();
    test_out_of_window();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data SRAM in the RI5CY test bench. It shares the RAM between the core load/store unit (port 0) and the debug/loader master (port 1), using a req/gnt/rvalid handshake on each port. It converts byte addresses and byte enables into the RAM's word address and 32-bit write mask, and routes the RAM's registered read data back to the port that issued the access. Accesses outside the RAM window are granted but terminated with an error instead of reaching the RAM.

## Interface
Parameters:
- BASE_ADDR, 32'h0010_0000: byte base of the RAM window. Bits [14:0] must be zero.
- ADDR_W, 13: RAM word-address width, giving a window of 2^ADDR_W words (32 KiB).

Ports:
- HCLK  in  1  clock; all state updates on the rising edge.
- HRESETn  in  1  reset; asynchronous, active-low.
- req0 / req1  in  1  access request, port 0 / port 1.
- gnt0 / gnt1  out  1  request accepted this cycle (combinational).
- addr0 / addr1  in  32  byte address; bits [1:0] ignored.
- we0 / we1  in  1  1 = write, 0 = read.
- be0 / be1  in  4  byte enables.
- wdata0 / wdata1  in  32  write data.
- rvalid0 / rvalid1  out  1  response valid, one cycle after gnt, for reads and writes.
- rdata0 / rdata1  out  32  read data; 0 for writes and errors.
- err0 / err1  out  1  out-of-window access; qualified by rvalid.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  word address, equal to addr[ADDR_W+1:2].
- ram_wmask  out  32  byte-expanded be; bit 8k+j = be[k].
- ram_wdata  out  32  write data.
- ram_rdata  in  32  registered RAM read data, valid the cycle after cs & ~we.

## Operation
Window check:
- in_win = (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).

Arbitration (combinational, each cycle):
- Only one request: that port wins.
- Both requesting: the winner is chosen by the configured policy (see Configuration).

Issue for the winner:
- Its gnt is 1.
- If in_win: ram_cs = 1; ram_we, ram_addr, ram_wmask and ram_wdata are taken from the winner.
- If not in_win: ram_cs = 0, and the error flag is recorded.
- The losing port's gnt is 0. It must hold its request stable until granted.

Response pipeline register, updated on every edge:
- rsp_vld: 1 if a grant occurred this cycle.
- rsp_id: the granted port.
- rsp_err: the error flag.
- rsp_we: the write flag.

Response outputs:
- rvalid<rsp_id> = rsp_vld.
- rdata<rsp_id> = ram_rdata when the response is a read and not an error; otherwise 0.
- err<rsp_id> = rsp_err.
- The non-owner port sees rvalid 0, rdata 0, err 0.

Other rules:
- With no request, ram_cs = 0 and all RAM outputs are 0.
- Reads return ram_rdata unmodified. The RAM already zeroes lanes outside wmask.

## Timing
- Grant latency: 0 cycles (gnt in the same cycle as req). Response: exactly 1 cycle after gnt.
- Throughput: one access per cycle. Back-to-back grants to alternating ports are allowed; the responses stay in grant order.
- Write then read to the same word on consecutive cycles returns the new data, because the RAM writes at the grant edge.
- be = 0 with req: the access is granted, ram_wmask = 0, and the response returns rdata 0.

Reset (HRESETn low, asynchronous):
- rsp_vld = 0, rsp_id = 0, rsp_err = 0, rsp_we = 0, last_winner = 1.
- gnt0, gnt1, ram_cs and ram_we are forced to 0, so a request in flight is not granted.
- All rvalid, err and rdata outputs are 0.
- A response pending at reset assertion is dropped and never delivered.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin.
  - On conflict, the port not equal to last_winner wins.
  - last_winner updates on every grant, including uncontested ones.
- DMEM_ARB_RR_EN undefined: fixed priority.
  - Port 0 always wins a conflict; last_winner is not implemented.
  - Port 1 can starve; this is acceptable for the loader use case.

## Structure
- Package dmem_arb_pkg holds:
  - typedef port_id_t (1 bit), with constants PORT_CORE = 0 and PORT_DBG = 1;
  - localparam WORD_BYTES = 4;
  - function be2mask(4) → 32.
- Sub-module dmem_arb_pick: combinational req0/req1 → winner/grant pick. It holds the last_winner flop under DMEM_ARB_RR_EN and is instantiated once.

## Test plan
- Port 0 reads 0x0010_0010 while RAM word 4 holds 0xDEADBEEF, be = 4'hF → gnt0 in the same cycle; next cycle rvalid0 = 1, rdata0 = 0xDEADBEEF, err0 = 0.
- Port 1 writes 0x0010_0008 with be = 4'b0100, wdata = 0x00AB0000; then port 1 reads the same word with be = 4'hF → ram_wmask = 0x00FF0000; the read returns the previous word with byte 2 = 0xAB.
- Both ports request for 4 cycles with DMEM_ARB_RR_EN defined → grants go 0, 1, 0, 1. Without the macro → grants are 0, 0, 0, 0, and gnt1 stays 0.
- Port 0 accesses 0x0000_1000 → gnt0 = 1, ram_cs = 0; next cycle rvalid0 = 1, err0 = 1, rdata0 = 0.
- Port 0 read granted, then HRESETn pulsed low before the next edge → rvalid0 never asserts; after release, grants resume and port 0 wins the first conflict.
- Port 0 read and port 1 write granted on alternating cycles for 8 cycles → each rvalid lands only on the issuing port, exactly 1 cycle after its gnt.
